alignment_marker_lane_rx: RTL



---
 rtl/alignment_marker_lane_rx.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/alignment_marker_lane_rx.sv
// alignment_marker_lane_rx: per-lane receive alignment-marker lock, marker
// deletion and BIP3/BIP7 checking for one 40G/100G PCS lane after block lock.
// Marker match ignores payload bytes 3 and 7 (BIP fields). All outputs are
// registered, one cycle after the block that produced them.
// Optional build macro AM_BIP_ERR_CNT_EN adds a saturating 16-bit BIP error
// counter output bip_err_cnt_o.
//
// Handshake: block_v_i qualifies data_i; there is no backpressure. data_v_o
// marks a forwarded data block, marker_v_o a deleted marker slot; both are 0
// on cycles that follow an idle (block_v_i=0) input cycle.
module alignment_marker_lane_rx #(
    parameter int          HEAD_W   = 2,
    parameter int          DATA_W   = 64,
    parameter int          BLOCK_W  = HEAD_W + DATA_W,
    parameter logic [63:0] LANE_ENC = 64'h00b8896f_00477690,
    parameter int          GAP      = 16383,
    parameter int          MISS_MAX = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               block_v_i,
    input  logic [BLOCK_W-1:0] data_i,
    output logic               data_v_o,
    output logic [BLOCK_W-1:0] data_o,
    output logic               marker_v_o,
    output logic               lock_o,
`ifdef AM_BIP_ERR_CNT_EN
    output logic               bip_err_o,
    output logic [15:0]        bip_err_cnt_o
`else
    output logic               bip_err_o
`endif
);

    localparam int CNT_W  = $clog2(GAP + 1);
    localparam int MISS_W = $clog2(MISS_MAX + 1);
    localparam logic [CNT_W-1:0]  GAP_C  = CNT_W'(GAP);
    localparam logic [MISS_W-1:0] MISS_C = MISS_W'(MISS_MAX);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [MISS_W-1:0]   miss_cnt, miss_n;
    logic [7:0]          bip_q, bip_n;
    logic                prev_ok, prev_n;
    logic [7:0]          blk_bip;
    logic                match, at_pos;
    logic                dv_n, mv_n, be_n;
    logic [7:0]          byte3, byte7;

    assign byte3  = data_i[33:26];
    assign byte7  = data_i[65:58];
    assign at_pos = (cnt == GAP_C);

    // Marker pattern match on sync header and the six fixed payload bytes
    always_comb begin
        match = (data_i[1:0] == 2'b10) &&
                (data_i[9:2]   == LANE_ENC[7:0])   &&
                (data_i[17:10] == LANE_ENC[15:8])  &&
                (data_i[25:18] == LANE_ENC[23:16]) &&
                (data_i[41:34] == LANE_ENC[39:32]) &&
                (data_i[49:42] == LANE_ENC[47:40]) &&
                (data_i[57:50] == LANE_ENC[55:48]);
    end

    // BIP contribution of the incoming block: header bits fold into lanes 3/4
    always_comb begin
        blk_bip = '0;
        for (int b = 0; b < BLOCK_W; b++) begin
            if (b < 2) blk_bip[b + 3] = blk_bip[b + 3] ^ data_i[b];
            else       blk_bip[(b - 2) % 8] = blk_bip[(b - 2) % 8] ^ data_i[b];
        end
    end

    // Next-state, position/miss counting, BIP accumulation and output decode
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        miss_n  = miss_cnt;
        bip_n   = bip_q;
        prev_n  = prev_ok;
        dv_n    = 1'b0;
        mv_n    = 1'b0;
        be_n    = 1'b0;
        if (block_v_i) begin
            bip_n = bip_q ^ blk_bip;
            dv_n  = 1'b1;
            case (state)
                HUNT: begin
                    if (match) begin
                        state_n = VERIFY;
                        cnt_n   = '0;
                        bip_n   = blk_bip;
                        prev_n  = 1'b1;
                    end
                end
                VERIFY: begin
                    if (at_pos) begin
                        cnt_n   = '0;
                        bip_n   = blk_bip;
                        prev_n  = match;
                        miss_n  = '0;
                        state_n = match ? LOCKED : HUNT;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                LOCKED: begin
                    if (at_pos) begin
                        // Expected slot is always deleted, matching or not
                        cnt_n  = '0;
                        bip_n  = blk_bip;
                        prev_n = match;
                        dv_n   = 1'b0;
                        mv_n   = 1'b1;
                        if (match) begin
                            miss_n = '0;
                            be_n   = prev_ok && ((byte3 != bip_q) || (byte7 != ~byte3));
                        end else begin
                            miss_n = miss_cnt + 1'b1;
                            if (miss_n == MISS_C) state_n = HUNT;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    // State registers and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= HUNT;
            cnt        <= '0;
            miss_cnt   <= '0;
            bip_q      <= '0;
            prev_ok    <= 1'b0;
            data_v_o   <= 1'b0;
            data_o     <= '0;
            marker_v_o <= 1'b0;
            lock_o     <= 1'b0;
            bip_err_o  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            miss_cnt   <= miss_n;
            bip_q      <= bip_n;
            prev_ok    <= prev_n;
            data_v_o   <= dv_n;
            marker_v_o <= mv_n;
            bip_err_o  <= be_n;
            lock_o     <= (state == LOCKED);
            if (block_v_i) data_o <= data_i;
        end
    end

`ifdef AM_BIP_ERR_CNT_EN
    // Saturating count of BIP errors, aligned with the bip_err_o pulse
    always_ff @(posedge clk) begin
        if (reset) bip_err_cnt_o <= '0;
        else if (be_n && (bip_err_cnt_o != 16'hffff)) bip_err_cnt_o <= bip_err_cnt_o + 16'd1;
    end
`endif

endmodule
